// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA controller for the ALU shift path.
// Shifts STEP bits per cycle behind a start/busy/done handshake.
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             shift,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] qa,
  input  logic [4:0]       sa,
  input  logic [WIDTH-1:0] qb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             amt_sel
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [4:0] STEP_V = 5'(STEP);

  state_t state, state_nxt;

  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] fill;
  logic [1:0]       op_q;
  logic             sign;
  logic [4:0]       count;
  logic [4:0]       amt;
  logic [4:0]       n;
  logic             accept;
  logic             last;
  logic             unused_qa;

  assign unused_qa = ^qa[WIDTH-1:5];

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_comb begin
    accept = start && (state == IDLE || state == DONE);
    amt    = shift ? sa : qa[4:0];
    if (op == 2'b11)
      amt = '0;
    n    = (count < STEP_V) ? count : STEP_V;
    last = (count <= STEP_V);
    // SRA fill comes from the sign latched at accept time
    fill = sign ? ~({WIDTH{1'b1}} >> n) : '0;
    unique case (op_q)
      2'b00:   shifted = data << n;
      2'b01:   shifted = data >> n;
      2'b10:   shifted = (data >> n) | fill;
      default: shifted = data;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept)
          state_nxt = (amt == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (last)
          state_nxt = DONE;
      end
      DONE: begin
        if (accept)
          state_nxt = (amt == '0) ? DONE : SHIFT;
        else
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data    <= '0;
      count   <= '0;
      op_q    <= '0;
      sign    <= 1'b0;
      result  <= '0;
      amt_sel <= 1'b0;
    end else if (accept) begin
      data    <= qb;
      count   <= amt;
      op_q    <= op;
      sign    <= qb[WIDTH-1];
      amt_sel <= shift;
      if (amt == '0)
        result <= qb;
    end else if (state == SHIFT) begin
      data  <= shifted;
      count <= count - n;
      if (last)
        result <= shifted;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: STEP=1 and STEP=4 instances share stimulus
// and are checked against an arithmetic reference model.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        shift;
  logic [1:0]  op;
  logic [31:0] qa;
  logic [4:0]  sa;
  logic [31:0] qb;

  logic [1:0]  busy_v;
  logic [1:0]  done_v;
  logic [1:0]  amt_sel_v;
  logic [31:0] result_v [2];

  int compared = 0;
  int mismatched = 0;
  int op_id = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(32), .STEP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .shift(shift), .op(op),
    .qa(qa), .sa(sa), .qb(qb),
    .busy(busy_v[0]), .done(done_v[0]),
    .result(result_v[0]), .amt_sel(amt_sel_v[0])
  );

  shift_sequencer #(.WIDTH(32), .STEP(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .shift(shift), .op(op),
    .qa(qa), .sa(sa), .qb(qb),
    .busy(busy_v[1]), .done(done_v[1]),
    .result(result_v[1]), .amt_sel(amt_sel_v[1])
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] o,
                                            input int amt,
                                            input logic [31:0] v);
    case (o)
      2'b00:   return v << amt;
      2'b01:   return v >> amt;
      2'b10:   return 32'($signed(v) >>> amt);
      default: return v;
    endcase
  endfunction

  task automatic scramble();
    shift = 1'($urandom);
    op    = 2'($urandom);
    qa    = $urandom;
    sa    = 5'($urandom);
    qb    = $urandom;
  endtask

  // One operation on both instances; chain leaves them in DONE
  task automatic run_op(input logic sh, input logic [1:0] o,
                        input logic [31:0] a, input logic [4:0] s,
                        input logic [31:0] b, input bit poke,
                        input bit chain);
    int amt, k [2], busy_n [2], done_n [2], done_at [2];
    logic [31:0] exp, res [2];
    logic        asel [2];
    int last;
    op_id++;
    amt = (o == 2'b11) ? 0 : (sh ? int'(s) : int'(a[4:0]));
    exp = ref_shift(o, amt, b);
    k[0] = amt;
    k[1] = (amt + 3) / 4;
    for (int d = 0; d < 2; d++) begin
      busy_n[d] = 0; done_n[d] = 0; done_at[d] = -1;
      res[d] = 'x; asel[d] = 1'bx;
    end
    start = 1'b1; shift = sh; op = o; qa = a; sa = s; qb = b;
    @(posedge clk);
    for (int j = 0; j < 45; j++) begin
      @(negedge clk);
      if (j == 0) begin
        start = 1'b0;
        scramble();
      end
      if (poke && j == 1) start = 1'b1;
      if (poke && j == 2) start = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (busy_v[d]) busy_n[d]++;
        if (done_v[d]) begin
          done_n[d]++;
          done_at[d] = j;
          res[d] = result_v[d];
          asel[d] = amt_sel_v[d];
        end
      end
      last = (done_at[0] > done_at[1]) ? done_at[0] : done_at[1];
      if (done_at[0] >= 0 && done_at[1] >= 0) begin
        if (chain) break;
        if (j >= last + 2) break;
      end
    end
    for (int d = 0; d < 2; d++) begin
      check($sformatf("op%0d s%0d done_at", op_id, d ? 4 : 1),
            32'(done_at[d]), 32'(k[d]));
      check($sformatf("op%0d s%0d busy_cycles", op_id, d ? 4 : 1),
            32'(busy_n[d]), 32'(k[d]));
      check($sformatf("op%0d s%0d done_pulses", op_id, d ? 4 : 1),
            32'(done_n[d]), 32'd1);
      check($sformatf("op%0d s%0d result", op_id, d ? 4 : 1),
            res[d], exp);
      check($sformatf("op%0d s%0d amt_sel", op_id, d ? 4 : 1),
            32'(asel[d]), 32'(sh));
      if (!chain)
        check($sformatf("op%0d s%0d result_hold", op_id, d ? 4 : 1),
              result_v[d], exp);
    end
  endtask

  initial begin
    int done_seen;
    logic        r_sh;
    logic [1:0]  r_op;
    logic [31:0] r_qa, r_qb;
    logic [4:0]  r_sa;
    int          r_amt;

    rst = 1'b1; start = 1'b0; shift = 1'b0; op = 2'b00;
    qa = '0; sa = '0; qb = '0;
    #12;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset s%0d busy", d), 32'(busy_v[d]), 32'd0);
      check($sformatf("reset s%0d done", d), 32'(done_v[d]), 32'd0);
      check($sformatf("reset s%0d result", d), result_v[d], 32'd0);
      check($sformatf("reset s%0d amt_sel", d), 32'(amt_sel_v[d]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(1'b1, 2'b00, 32'h0, 5'd4, 32'h0000_00F1, 1'b0, 1'b0);
    run_op(1'b0, 2'b10, 32'hFFFF_FFE3, 5'd17, 32'h8000_0000, 1'b0, 1'b0);
    run_op(1'b1, 2'b01, 32'h0, 5'd0, 32'h1234_5678, 1'b0, 1'b0);
    run_op(1'b1, 2'b11, 32'h0, 5'd9, 32'h1234_5678, 1'b0, 1'b0);
    run_op(1'b1, 2'b00, 32'h0, 5'd20, 32'hA5A5_0F0F, 1'b1, 1'b0);
    run_op(1'b1, 2'b11, 32'h0, 5'd3, 32'hDEAD_BEEF, 1'b0, 1'b1);
    run_op(1'b1, 2'b00, 32'h0, 5'd1, 32'h0000_0001, 1'b0, 1'b0);
    run_op(1'b1, 2'b01, 32'h0, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(1'b1, 2'b00, 32'h0, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(1'b1, 2'b10, 32'h0, 5'd31, 32'h8000_0001, 1'b0, 1'b0);

    // Abort mid-shift: everything clears and no done follows
    start = 1'b1; shift = 1'b1; op = 2'b00; sa = 5'd20; qb = 32'h1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("abort s%0d busy", d), 32'(busy_v[d]), 32'd0);
      check($sformatf("abort s%0d done", d), 32'(done_v[d]), 32'd0);
      check($sformatf("abort s%0d result", d), result_v[d], 32'd0);
      check($sformatf("abort s%0d amt_sel", d), 32'(amt_sel_v[d]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_v != 2'b00) done_seen++;
    end
    check("abort no_done", 32'(done_seen), 32'd0);

    for (int i = 0; i < 150; i++) begin
      r_sh = 1'($urandom);
      r_op = 2'($urandom);
      r_qa = $urandom;
      r_sa = 5'($urandom);
      r_qb = $urandom;
      r_amt = (r_op == 2'b11) ? 0 : (r_sh ? int'(r_sa) : int'(r_qa[4:0]));
      run_op(r_sh, r_op, r_qa, r_sa, r_qb,
             (r_amt >= 13) && 1'($urandom), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
